// File: rtl/ui_event_pkg.sv
// Shared types and default constants for the ui_in switch event receiver.
// One event records the debounced level vector and the bits that changed.
package ui_event_pkg;

    localparam int UI_WIDTH         = 8;
    localparam int UI_SYNC_STAGES   = 2;
    localparam int UI_STABLE_CYCLES = 4;
    localparam int UI_EV_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [UI_WIDTH-1:0] level;
        logic [UI_WIDTH-1:0] mask;
    } ui_event_t;

endpackage

// File: rtl/ui_event_fifo.sv
// Synchronous event FIFO with registered-only output (no fall-through).
// A push into a full queue is accepted only when a pop happens on the same edge.
module ui_event_fifo
    import ui_event_pkg::*;
#(
    parameter int DEPTH = UI_EV_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  ui_event_t push_data,
    output logic      full,
    input  logic      pop,
    output ui_event_t pop_data,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    ui_event_t       mem [DEPTH];
    logic [AW:0]     wr_q;
    logic [AW:0]     rd_q;
    logic            do_push;
    logic            do_pop;

    // The extra pointer bit distinguishes a full queue from an empty one.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ui_switch_event_rx.sv
// Synchronises and debounces the ui_in pins, publishes the debounced levels,
// and queues one event per edge on which any debounced bit changes.
module ui_switch_event_rx
    import ui_event_pkg::*;
#(
    parameter int WIDTH         = UI_WIDTH,
    parameter int SYNC_STAGES   = UI_SYNC_STAGES,
    parameter int STABLE_CYCLES = UI_STABLE_CYCLES,
    parameter int FIFO_DEPTH    = UI_EV_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ui_in,
    output logic [WIDTH-1:0] sw_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_level,
    output logic [WIDTH-1:0] ev_mask,
    output logic             ev_overflow,
    input  logic             overflow_clr
);

    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] sw_q;
    logic             ovf_q;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    ui_event_t        push_ev;
    ui_event_t        head_ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;

        always_ff @(posedge clk) begin
            if (reset) sync_q <= '0;
            else       sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[i]};
        end

        assign s[i] = sync_q[SYNC_STAGES-1];

        // Counter restarts on agreement or after a flip, so every flip needs a full fresh run.
        always_ff @(posedge clk) begin
            if (reset)                                   cnt_q <= '0;
            else if ((s[i] == sw_q[i]) || (cnt_q == CNT_MAX)) cnt_q <= '0;
            else                                         cnt_q <= cnt_q + CW'(1);
        end

        assign flip[i] = (s[i] != sw_q[i]) && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) sw_q <= '0;
        else       sw_q <= sw_q ^ flip;
    end

    assign push          = |flip;
    assign push_ev.level = sw_q ^ flip;
    assign push_ev.mask  = flip;

    ui_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .full      (fifo_full),
        .pop       (ev_ready),
        .pop_data  (head_ev),
        .empty     (fifo_empty)
    );

    assign drop = push && fifo_full && !(ev_ready && !fifo_empty);

    // A fresh drop takes priority over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset)             ovf_q <= 1'b0;
        else if (drop)         ovf_q <= 1'b1;
        else if (overflow_clr) ovf_q <= 1'b0;
    end

    assign sw_state    = sw_q;
    assign ev_valid    = !fifo_empty;
    assign ev_level    = head_ev.level;
    assign ev_mask     = head_ev.mask;
    assign ev_overflow = ovf_q;

endmodule
